// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory opcodes, exception
// codes and the opcode decoder used to classify loads and stores.
package mem_stage_pkg;

    localparam int DM_ADDR_BITS_DEFAULT = 12;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        SIZE_NONE,
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } acc_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        acc_size_e size;
        logic      sign_ext;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        mem_op_t op;
        op.is_load  = 1'b0;
        op.is_store = 1'b0;
        op.size     = SIZE_NONE;
        op.sign_ext = 1'b0;
        case (opcode)
            OP_LW:   begin op.is_load  = 1'b1; op.size = SIZE_WORD; end
            OP_LH:   begin op.is_load  = 1'b1; op.size = SIZE_HALF; op.sign_ext = 1'b1; end
            OP_LHU:  begin op.is_load  = 1'b1; op.size = SIZE_HALF; end
            OP_LB:   begin op.is_load  = 1'b1; op.size = SIZE_BYTE; op.sign_ext = 1'b1; end
            OP_LBU:  begin op.is_load  = 1'b1; op.size = SIZE_BYTE; end
            OP_SW:   begin op.is_store = 1'b1; op.size = SIZE_WORD; end
            OP_SH:   begin op.is_store = 1'b1; op.size = SIZE_HALF; end
            OP_SB:   begin op.is_store = 1'b1; op.size = SIZE_BYTE; end
            default: ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage bundled as one port.
interface mem_stage_if;

    logic [31:0] IR_M;
    logic [31:0] PC8_M;
    logic [31:0] ALUOUT_M;
    logic [31:0] RT_M;
    logic [31:0] XALUOUT_M;
    logic [4:0]  EXC_M;
    logic        Forward_RT_M;
    logic [31:0] mux_Wdata_out;
    logic        MEM_WB_clr;

    logic [4:0]  EXC_M_out;
    logic [31:0] IR_W;
    logic [31:0] PC8_W;
    logic [31:0] ALUOUT_W;
    logic [31:0] XALUOUT_W;
    logic [31:0] DR_W;
    logic [4:0]  EXC_W;

    modport master (
        output IR_M, PC8_M, ALUOUT_M, RT_M, XALUOUT_M, EXC_M,
               Forward_RT_M, mux_Wdata_out, MEM_WB_clr,
        input  EXC_M_out, IR_W, PC8_W, ALUOUT_W, XALUOUT_W, DR_W, EXC_W
    );

    modport slave (
        input  IR_M, PC8_M, ALUOUT_M, RT_M, XALUOUT_M, EXC_M,
               Forward_RT_M, mux_Wdata_out, MEM_WB_clr,
        output EXC_M_out, IR_W, PC8_W, ALUOUT_W, XALUOUT_W, DR_W, EXC_W
    );

endinterface

// File: rtl/mem_stage_dm_bank.sv
// Byte-enabled data memory: synchronous write and clear, combinational read.
module dm_bank
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS = DM_ADDR_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [3:0]           byte_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access with lane select/extension, address
// exception detection and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DM_ADDR_BITS = DM_ADDR_BITS_DEFAULT
) (
    input logic       clk,
    input logic       reset,
    mem_stage_if.slave bus
);

    mem_op_t     op;
    logic [31:0] addr;
    logic        misaligned;
    logic        out_of_range;
    logic [4:0]  exc_code;
    logic [31:0] store_data;
    logic [31:0] lane_wdata;
    logic [3:0]  byte_en;
    logic        mem_we;
    logic [31:0] rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign op           = decode_mem_op(bus.IR_M[31:26]);
    assign addr         = bus.ALUOUT_M;
    assign out_of_range = (addr >> (DM_ADDR_BITS + 2)) != 32'd0;

    always_comb begin
        misaligned = 1'b0;
        case (op.size)
            SIZE_WORD: misaligned = addr[1:0] != 2'b00;
            SIZE_HALF: misaligned = addr[0];
            default:   misaligned = 1'b0;
        endcase
    end

    // An exception from an earlier stage always wins over our own detection.
    always_comb begin
        exc_code = EXC_NONE;
        if (bus.EXC_M != EXC_NONE) begin
            exc_code = bus.EXC_M;
        end else if ((op.is_load || op.is_store) && (misaligned || out_of_range)) begin
            exc_code = op.is_load ? EXC_ADEL : EXC_ADES;
        end
    end

    assign bus.EXC_M_out = exc_code;

    assign store_data = bus.Forward_RT_M ? bus.mux_Wdata_out : bus.RT_M;
    assign mem_we     = op.is_store && (exc_code == EXC_NONE) && !bus.MEM_WB_clr && !reset;

    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = store_data;
        case (op.size)
            SIZE_WORD: byte_en = 4'b1111;
            SIZE_HALF: begin
                byte_en    = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data[15:0]}};
            end
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            default: byte_en = 4'b0000;
        endcase
    end

    dm_bank #(
        .ADDR_BITS(DM_ADDR_BITS)
    ) u_dm_bank (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_we),
        .byte_en(byte_en),
        .addr   (addr[DM_ADDR_BITS+1:2]),
        .wdata  (lane_wdata),
        .rdata  (rdata)
    );

    assign byte_sel = rdata[8*addr[1:0] +: 8];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = '0;
        if (op.is_load) begin
            case (op.size)
                SIZE_WORD: load_data = rdata;
                SIZE_HALF: load_data = {{16{op.sign_ext & half_sel[15]}}, half_sel};
                SIZE_BYTE: load_data = {{24{op.sign_ext & byte_sel[7]}}, byte_sel};
                default:   load_data = '0;
            endcase
        end
    end

    // A flush loads a NOP bubble into MEM/WB exactly like reset does.
    always_ff @(posedge clk) begin
        if (reset || bus.MEM_WB_clr) begin
            bus.IR_W      <= '0;
            bus.PC8_W     <= '0;
            bus.ALUOUT_W  <= '0;
            bus.XALUOUT_W <= '0;
            bus.DR_W      <= '0;
            bus.EXC_W     <= '0;
        end else begin
            bus.IR_W      <= bus.IR_M;
            bus.PC8_W     <= bus.PC8_M;
            bus.ALUOUT_W  <= bus.ALUOUT_M;
            bus.XALUOUT_W <= bus.XALUOUT_M;
            bus.DR_W      <= load_data;
            bus.EXC_W     <= exc_code;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of one-cycle instructions with
// scoreboarded MEM/WB expectations, plus a mid-stream reset sequence.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(
        .DM_ADDR_BITS(12)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  excm;
        logic        fwd;
        logic [31:0] wdata;
        logic        clr;
        logic [4:0]  exp_exc;
        logic [31:0] exp_dr;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [31:0] alu;
        logic [31:0] xalu;
        logic [31:0] dr;
        logic [4:0]  exc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic addVec(input string name, input logic [5:0] op, input logic [31:0] alu,
                          input logic [31:0] rt, input logic [4:0] excm, input logic fwd,
                          input logic [31:0] wdata, input logic clr,
                          input logic [4:0] exp_exc, input logic [31:0] exp_dr);
        vec_t v;
        v.name = name; v.op = op; v.alu = alu; v.rt = rt; v.excm = excm;
        v.fwd = fwd; v.wdata = wdata; v.clr = clr; v.exp_exc = exp_exc; v.exp_dr = exp_dr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t        e;
        logic [31:0] ir;
        ir                = {v.op, 5'd4, 5'd9, 16'(idx)};
        bus.IR_M          = ir;
        bus.PC8_M         = 32'h0040_0008 + 32'(4 * idx);
        bus.ALUOUT_M      = v.alu;
        bus.RT_M          = v.rt;
        bus.XALUOUT_M     = 32'hA5A5_0000 | 32'(idx);
        bus.EXC_M         = v.excm;
        bus.Forward_RT_M  = v.fwd;
        bus.mux_Wdata_out = v.wdata;
        bus.MEM_WB_clr    = v.clr;
        #1;
        check({v.name, " EXC_M_out"}, {27'b0, bus.EXC_M_out}, {27'b0, v.exp_exc});
        e.name = v.name;
        if (v.clr) begin
            e.ir = '0; e.pc8 = '0; e.alu = '0; e.xalu = '0; e.dr = '0; e.exc = '0;
        end else begin
            e.ir   = ir;
            e.pc8  = bus.PC8_M;
            e.alu  = v.alu;
            e.xalu = bus.XALUOUT_M;
            e.dr   = v.exp_dr;
            e.exc  = v.exp_exc;
        end
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: actual=empty required=entry");
        end else begin
            e = sb_q.pop_front();
            check({e.name, " IR_W"},      bus.IR_W,      e.ir);
            check({e.name, " PC8_W"},     bus.PC8_W,     e.pc8);
            check({e.name, " ALUOUT_W"},  bus.ALUOUT_W,  e.alu);
            check({e.name, " XALUOUT_W"}, bus.XALUOUT_W, e.xalu);
            check({e.name, " DR_W"},      bus.DR_W,      e.dr);
            check({e.name, " EXC_W"},     {27'b0, bus.EXC_W}, {27'b0, e.exc});
        end
    endtask

    task automatic checkAllZero(input string name);
        check({name, " IR_W"},      bus.IR_W,      32'h0);
        check({name, " PC8_W"},     bus.PC8_W,     32'h0);
        check({name, " ALUOUT_W"},  bus.ALUOUT_W,  32'h0);
        check({name, " XALUOUT_W"}, bus.XALUOUT_W, 32'h0);
        check({name, " DR_W"},      bus.DR_W,      32'h0);
        check({name, " EXC_W"},     {27'b0, bus.EXC_W}, 32'h0);
    endtask

    localparam logic [31:0] JUNK = 32'h9999_9999;

    initial begin
        vec_t v;
        //      name            op      alu          rt            excm  fwd   wdata         clr   exc   dr
        addVec("sw 0x10",      OP_SW,  32'h10,   32'h1234_5678, 5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("lw 0x10",      OP_LW,  32'h10,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h1234_5678);
        addVec("sb 0x13",      OP_SB,  32'h13,   32'h1234_56AB, 5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("lb 0x13",      OP_LB,  32'h13,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'hFFFF_FFAB);
        addVec("lbu 0x13",     OP_LBU, 32'h13,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0000_00AB);
        addVec("lw after sb",  OP_LW,  32'h10,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'hAB34_5678);
        addVec("sh 0x12",      OP_SH,  32'h12,   32'hFFFF_8001, 5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("lh 0x12",      OP_LH,  32'h12,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'hFFFF_8001);
        addVec("lhu 0x12",     OP_LHU, 32'h12,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0000_8001);
        addVec("lh 0x11 AdEL", OP_LH,  32'h11,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd4, 32'h0000_5678);
        addVec("lw after sh",  OP_LW,  32'h10,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h8001_5678);
        addVec("sh 0x10",      OP_SH,  32'h10,   32'h0000_1234, 5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("lw sh low",    OP_LW,  32'h10,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h8001_1234);
        addVec("sw 0x6 AdES",  OP_SW,  32'h6,    32'hDEAD_BEEF, 5'd0, 1'b0, JUNK,         1'b0, 5'd5, 32'h0);
        addVec("lw 0x4",       OP_LW,  32'h4,    32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("sw 0x4000",    OP_SW,  32'h4000, 32'hDEAD_BEEF, 5'd0, 1'b0, JUNK,         1'b0, 5'd5, 32'h0);
        addVec("lw 0x0",       OP_LW,  32'h0,    32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("sw EXC_M=12",  OP_SW,  32'h8,    32'h1111_1111, 5'd12,1'b0, JUNK,         1'b0, 5'd12,32'h0);
        addVec("lw 0x8 a",     OP_LW,  32'h8,    32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("sw flushed",   OP_SW,  32'h8,    32'h2222_2222, 5'd0, 1'b0, JUNK,         1'b1, 5'd0, 32'h0);
        addVec("lw 0x8 b",     OP_LW,  32'h8,    32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("sw fwd 0x20",  OP_SW,  32'h20,   32'h3333_3333, 5'd0, 1'b1, 32'hCAFE_BABE,1'b0, 5'd0, 32'h0);
        addVec("lw 0x20",      OP_LW,  32'h20,   32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'hCAFE_BABE);
        addVec("lw EXC_M=3",   OP_LW,  32'h11,   32'h0,         5'd3, 1'b0, JUNK,         1'b0, 5'd3, 32'h8001_1234);
        addVec("lui unaligned",6'h0F,  32'h3,    32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("sb 0x3FFF",    OP_SB,  32'h3FFF, 32'h0000_005A, 5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0);
        addVec("lb 0x3FFF",    OP_LB,  32'h3FFF, 32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h0000_005A);
        addVec("lw 0x3FFC",    OP_LW,  32'h3FFC, 32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd0, 32'h5A00_0000);
        addVec("lw 0x4000",    OP_LW,  32'h4000, 32'h0,         5'd0, 1'b0, JUNK,         1'b0, 5'd4, 32'h0);

        reset             = 1'b1;
        bus.IR_M          = '0;
        bus.PC8_M         = 32'h1234;
        bus.ALUOUT_M      = '0;
        bus.RT_M          = '0;
        bus.XALUOUT_M     = 32'h5678;
        bus.EXC_M         = '0;
        bus.Forward_RT_M  = 1'b0;
        bus.mux_Wdata_out = '0;
        bus.MEM_WB_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        check("reset EXC_M_out", {27'b0, bus.EXC_M_out}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end

        // Mid-stream reset with a store in flight: the store must not land.
        v = vecs[0];
        v.name = "sw under reset"; v.alu = 32'h24; v.rt = 32'h7777_7777;
        reset = 1'b1;
        applyStimulus(v, 100);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        checkAllZero("mid reset");
        reset = 1'b0;

        v = vecs[1];
        v.name = "lw 0x20 post reset"; v.alu = 32'h20; v.exp_dr = 32'h0;
        applyStimulus(v, 101);
        checkOutput();
        v.name = "lw 0x24 post reset"; v.alu = 32'h24;
        applyStimulus(v, 102);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory pipeline stage of the five-stage MIPS core, directly downstream of the execute stage. Takes the EX/MEM values (instruction, ALU result used as address, store data, multiply/divide result, PC+8, pending exception code) and performs data-memory loads and stores with byte/halfword selection. Detects address exceptions and registers everything into the MEM/WB pipeline register for the write-back stage.

## Interface
Parameters:
- DM_ADDR_BITS, 12: word-address width; memory holds 2^DM_ADDR_BITS 32-bit words, byte range 0 .. 4*2^DM_ADDR_BITS-1.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears pipeline registers and data memory.
- IR_M  in  32  instruction in MEM.
- PC8_M  in  32  PC+8 of that instruction.
- ALUOUT_M  in  32  ALU result; byte address for loads/stores.
- RT_M  in  32  store data as forwarded by EX.
- XALUOUT_M  in  32  HI/LO read result.
- EXC_M  in  5  exception code from earlier stages; 0 = none.
- Forward_RT_M  in  1  0: store data = RT_M; 1: store data = mux_Wdata_out.
- mux_Wdata_out  in  32  register write-back value from WB.
- MEM_WB_clr  in  1  flush: suppress store this cycle, load NOP into MEM/WB.
- EXC_M_out  out  5  final MEM-stage exception code (combinational), to CP0.
- IR_W, PC8_W, ALUOUT_W, XALUOUT_W, DR_W  out  32 each  MEM/WB registers; DR_W is extended load data.
- EXC_W  out  5  registered exception code.

## Operation
- Opcodes: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28. All others: no memory access, DR_W loaded with 0.
- Word index = ALUOUT_M[DM_ADDR_BITS+1:2]; byte lane = ALUOUT_M[1:0], little-endian (lane 0 = bits 7:0).
- Address exception detected when any holds:
  - word access with ALUOUT_M[1:0] != 0;
  - halfword access with ALUOUT_M[0] = 1;
  - ALUOUT_M >= 4*2^DM_ADDR_BITS (unsigned).
  - Load → code 4 (AdEL), store → code 5 (AdES).
- Priority: nonzero EXC_M passes through unchanged; otherwise detected code; otherwise 0. Result drives EXC_M_out and feeds EXC_W.
- Store write enable = store opcode AND EXC_M_out == 0 AND MEM_WB_clr == 0 AND reset == 0. Byte enables: sw 1111; sh 0011 or 1100 by ALUOUT_M[1]; sb one-hot by ALUOUT_M[1:0]. Store data lane-replicated: sb {4{d[7:0]}}, sh {2{d[15:0]}}.
- Load read is combinational from the array; lane selected and extended (lb/lh sign, lbu/lhu zero) before registering. Excepting loads still register their extended data; WB ignores it.

## Timing
- Memory write and all MEM/WB registers update on the same rising edge; load data visible at DR_W one cycle after the instruction is in MEM.
- Load of an address stored by the immediately preceding instruction: store commits at edge N, load in MEM during cycle N+1 reads the new value. No internal bypass is needed.
- reset: all outputs registered to 0 (IR_W = 0 is NOP), all memory words 0. EXC_M_out remains combinational from its inputs.
- MEM_WB_clr (not reset): IR_W, PC8_W, ALUOUT_W, XALUOUT_W, DR_W, EXC_W = 0 on next edge; store suppressed in the same cycle; memory otherwise retained.
- reset and MEM_WB_clr together: reset behaviour.
- No stall input; the stage advances every cycle.

## Structure
- Shared package: opcode constants, exception codes (AdEL = 4, AdES = 5, none = 0), DM_ADDR_BITS default.
- One natural sub-module: dm_bank, holding the byte-enabled word array, synchronous write, combinational read, synchronous clear on reset. Lane select, extension, exception logic and MEM/WB register stay in mem_stage.

## Test plan
- sw 0x12345678 to 0x10, then lw 0x10 next cycle → DR_W = 0x12345678, EXC_W = 0.
- sb 0xAB to 0x13, then lb 0x13 → DR_W = 0xFFFFFFAB; lbu 0x13 → 0x000000AB; word 0x10 = 0xAB345678.
- sh 0x8001 to 0x12, then lh 0x12 → 0xFFFF8001; lhu → 0x00008001; lh 0x11 → EXC_W = 4, memory unchanged.
- sw to 0x6 → EXC_M_out = 5, no write; sw to 0x4000 (DM_ADDR_BITS = 12) → code 5, no write.
- sw with EXC_M = 12 → EXC_W = 12, no write; sw with MEM_WB_clr = 1 → no write, IR_W = 0 next cycle.
- Forward_RT_M = 1, mux_Wdata_out = 0xCAFEBABE, sw 0x20 → word 0x20 = 0xCAFEBABE. Reset mid-stream → all outputs 0, lw 0x20 afterwards returns 0.
